// File: rtl/complex_mult_pipe.sv
// Three-stage pipelined complex multiplier y = a*b or a*conj(b) in Q(WIDTH-FRAC).FRAC format,
// with a valid/ready handshake that freezes the whole pipeline on output backpressure.
module complex_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = WIDTH / 2,
    parameter bit ROUND = 1'b1,
    parameter bit SAT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    input  logic                    conj_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] y_re,
    output logic signed [WIDTH-1:0] y_im,
    output logic                    ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 1;

    localparam logic signed [SW-1:0] RND  = ROUND ? (SW'(1) << (FRAC - 1)) : '0;
    localparam logic signed [SW-1:0] MAXV = {{(SW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    // Returns {out_of_range, result}; the range flag is independent of SAT so ovf always reports.
    function automatic logic [WIDTH:0] scale(input logic signed [SW-1:0] sum);
        logic signed [SW-1:0] r;
        logic                 hi;
        logic                 lo;
        logic [WIDTH-1:0]     y;
        r  = (sum + RND) >>> FRAC;
        hi = (r > MAXV);
        lo = (r < MINV);
        if (SAT && hi) begin
            y = MAXV[WIDTH-1:0];
        end else if (SAT && lo) begin
            y = MINV[WIDTH-1:0];
        end else begin
            y = r[WIDTH-1:0];
        end
        return {hi | lo, y};
    endfunction

    logic                    adv;

    logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                    cj1_q, cj1_d, cj2_q, cj2_d;
    logic signed [WIDTH-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
    logic signed [PW-1:0]    rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
    logic signed [WIDTH-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
    logic                    ovf_q, ovf_d;

    logic signed [SW-1:0]    re_sum, im_sum;
    logic [WIDTH:0]          re_res, im_res;

    always_comb begin
        adv = ~(v3_q & ~out_ready);

        re_sum = cj2_q ? (SW'(rr_q) + SW'(ii_q)) : (SW'(rr_q) - SW'(ii_q));
        im_sum = cj2_q ? (SW'(ir_q) - SW'(ri_q)) : (SW'(ri_q) + SW'(ir_q));
        re_res = scale(re_sum);
        im_res = scale(im_sum);

        v1_d   = v1_q;
        v2_d   = v2_q;
        v3_d   = v3_q;
        cj1_d  = cj1_q;
        cj2_d  = cj2_q;
        ar_d   = ar_q;
        ai_d   = ai_q;
        br_d   = br_q;
        bi_d   = bi_q;
        rr_d   = rr_q;
        ii_d   = ii_q;
        ri_d   = ri_q;
        ir_d   = ir_q;
        y_re_d = y_re_q;
        y_im_d = y_im_q;
        // Only valid samples landing in S3 may raise the sticky flag.
        ovf_d  = ovf_q | (adv & v2_q & (re_res[WIDTH] | im_res[WIDTH]));

        if (adv) begin
            v1_d   = in_valid;
            cj1_d  = conj_en;
            ar_d   = a_re;
            ai_d   = a_im;
            br_d   = b_re;
            bi_d   = b_im;

            v2_d   = v1_q;
            cj2_d  = cj1_q;
            rr_d   = PW'(ar_q) * PW'(br_q);
            ii_d   = PW'(ai_q) * PW'(bi_q);
            ri_d   = PW'(ar_q) * PW'(bi_q);
            ir_d   = PW'(ai_q) * PW'(br_q);

            v3_d   = v2_q;
            y_re_d = re_res[WIDTH-1:0];
            y_im_d = im_res[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            cj1_q  <= 1'b0;
            cj2_q  <= 1'b0;
            ar_q   <= '0;
            ai_q   <= '0;
            br_q   <= '0;
            bi_q   <= '0;
            rr_q   <= '0;
            ii_q   <= '0;
            ri_q   <= '0;
            ir_q   <= '0;
            y_re_q <= '0;
            y_im_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            cj1_q  <= cj1_d;
            cj2_q  <= cj2_d;
            ar_q   <= ar_d;
            ai_q   <= ai_d;
            br_q   <= br_d;
            bi_q   <= bi_d;
            rr_q   <= rr_d;
            ii_q   <= ii_d;
            ri_q   <= ri_d;
            ir_q   <= ir_d;
            y_re_q <= y_re_d;
            y_im_q <= y_im_d;
            ovf_q  <= ovf_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Bench for complex_mult_pipe: a round/saturate instance and a truncate/wrap instance share
// stimulus; expected results are queued at acceptance and compared when each output transfers.
module tb_complex_mult_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        conj_en = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;

    logic        in_ready, out_valid, ovf;
    logic [15:0] y_re, y_im;
    logic        in_ready_w, out_valid_w, ovf_w;
    logic [15:0] y_re_w, y_im_w;

    complex_mult_pipe #(.WIDTH(16), .FRAC(8), .ROUND(1'b1), .SAT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .conj_en(conj_en),
        .out_valid(out_valid), .out_ready(out_ready), .y_re(y_re), .y_im(y_im), .ovf(ovf)
    );

    complex_mult_pipe #(.WIDTH(16), .FRAC(8), .ROUND(1'b0), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .conj_en(conj_en),
        .out_valid(out_valid_w), .out_ready(out_ready), .y_re(y_re_w), .y_im(y_im_w),
        .ovf(ovf_w)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [15:0] re_w;
        logic [15:0] im_w;
        logic        ovf;
        logic        ovf_w;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_ovf = 1'b0;
    logic exp_ovf_w = 1'b0;

    function automatic void scale(input longint v, input bit rnd, input bit sat,
                                  output logic [15:0] y, output bit o);
        longint r;
        r = (rnd ? v + 128 : v) >>> 8;
        o = (r > 32767) || (r < -32768);
        if (sat && r > 32767) y = 16'h7fff;
        else if (sat && r < -32768) y = 16'h8000;
        else y = r[15:0];
    endfunction

    function automatic exp_t model(input logic [15:0] ar, ai, br, bi, input logic cj);
        longint rr, ii, ri, ir, re, im;
        logic [15:0] y0, y1, y2, y3;
        bit o0, o1, o2, o3;
        exp_t e;
        rr = longint'($signed(ar)) * longint'($signed(br));
        ii = longint'($signed(ai)) * longint'($signed(bi));
        ri = longint'($signed(ar)) * longint'($signed(bi));
        ir = longint'($signed(ai)) * longint'($signed(br));
        re = cj ? rr + ii : rr - ii;
        im = cj ? ir - ri : ri + ir;
        scale(re, 1'b1, 1'b1, y0, o0);
        scale(im, 1'b1, 1'b1, y1, o1);
        scale(re, 1'b0, 1'b0, y2, o2);
        scale(im, 1'b0, 1'b0, y3, o3);
        e.re = y0; e.im = y1; e.re_w = y2; e.im_w = y3;
        e.ovf = o0 | o1; e.ovf_w = o2 | o3;
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] re, im, re_w, im_w, input logic o, o_w);
        exp_t e;
        e.re = re; e.im = im; e.re_w = re_w; e.im_w = im_w; e.ovf = o; e.ovf_w = o_w;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one sample for a single cycle; queues its expectation if it was accepted.
    task automatic send(input logic [15:0] ar, ai, br, bi, input logic cj, input exp_t e);
        in_valid = 1'b1; a_re = ar; a_im = ai; b_re = br; b_im = bi; conj_en = cj;
        #1;
        if (in_ready) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts clock edges since acceptance until out_valid, bounded.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 12) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        in_valid = 1'b1; a_re = 16'h1234; a_im = 16'h5678; b_re = 16'h0100; b_im = 16'h0100;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        repeat (3) tick;
        checks++;
        if ({out_valid, out_valid_w} !== 2'b00) begin
            errors++; $display("FAIL reset_valid got %b%b need 00", out_valid, out_valid_w);
        end
        checks++;
        if ({y_re, y_im, y_re_w, y_im_w} !== 64'h0) begin
            errors++; $display("FAIL reset_y got %h %h %h %h need 0", y_re, y_im, y_re_w, y_im_w);
        end
        checks++;
        if ({ovf, ovf_w} !== 2'b00) begin
            errors++; $display("FAIL reset_ovf got %b%b need 00", ovf, ovf_w);
        end
        checks++;
        if ({in_ready, in_ready_w} !== 2'b11) begin
            errors++; $display("FAIL reset_ready got %b%b need 11", in_ready, in_ready_w);
        end
        in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (4) tick;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release got out_valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_basic;
        exp_t e; int n;
        out_ready = 1'b1;
        send(16'h0100, 16'h0000, 16'h0080, 16'h0080, 1'b0,
             mk(16'h0080, 16'h0080, 16'h0080, 16'h0080, 1'b0, 1'b0));
        wait_out(n);
        checks++;
        if (n != 3 || out_valid_w !== 1'b1) begin
            errors++; $display("FAIL basic_latency got %0d need 3", n);
        end
        e = sb.pop_front(); exp_ovf |= e.ovf; exp_ovf_w |= e.ovf_w;
        checks++;
        if ({y_re, y_im, y_re_w, y_im_w} !== {e.re, e.im, e.re_w, e.im_w}) begin
            errors++; $display("FAIL basic_y got %h %h %h %h need %h %h %h %h",
                               y_re, y_im, y_re_w, y_im_w, e.re, e.im, e.re_w, e.im_w);
        end
        checks++;
        if ({ovf, ovf_w} !== {exp_ovf, exp_ovf_w}) begin
            errors++; $display("FAIL basic_ovf got %b%b need %b%b", ovf, ovf_w, exp_ovf, exp_ovf_w);
        end
        tick;
    endtask

    task automatic test_conjugate;
        exp_t e; int n;
        send(16'h0100, 16'h0100, 16'h0080, 16'h0080, 1'b1,
             mk(16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0));
        wait_out(n);
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL conj_latency got %0d need 3", n);
        end
        e = sb.pop_front(); exp_ovf |= e.ovf; exp_ovf_w |= e.ovf_w;
        checks++;
        if ({y_re, y_im, y_re_w, y_im_w} !== {e.re, e.im, e.re_w, e.im_w}) begin
            errors++; $display("FAIL conj_y got %h %h %h %h need %h %h %h %h",
                               y_re, y_im, y_re_w, y_im_w, e.re, e.im, e.re_w, e.im_w);
        end
        tick;
    endtask

    task automatic test_rounding;
        exp_t e; int n;
        send(16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b0,
             mk(16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0));
        wait_out(n);
        e = sb.pop_front(); exp_ovf |= e.ovf; exp_ovf_w |= e.ovf_w;
        checks++;
        if ({y_re, y_im} !== {e.re, e.im}) begin
            errors++; $display("FAIL round_half_up got %h %h need %h %h", y_re, y_im, e.re, e.im);
        end
        checks++;
        if ({y_re_w, y_im_w} !== {e.re_w, e.im_w}) begin
            errors++; $display("FAIL round_trunc got %h %h need %h %h",
                               y_re_w, y_im_w, e.re_w, e.im_w);
        end
        checks++;
        if ({ovf, ovf_w} !== {exp_ovf, exp_ovf_w}) begin
            errors++; $display("FAIL round_ovf got %b%b need %b%b", ovf, ovf_w, exp_ovf, exp_ovf_w);
        end
        tick;
    endtask

    task automatic test_overflow;
        exp_t e; int n;
        send(16'h8000, 16'h0000, 16'hff00, 16'h0000, 1'b0,
             mk(16'h7fff, 16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b1));
        wait_out(n);
        e = sb.pop_front(); exp_ovf |= e.ovf; exp_ovf_w |= e.ovf_w;
        checks++;
        if ({y_re, y_im, y_re_w, y_im_w} !== {e.re, e.im, e.re_w, e.im_w}) begin
            errors++; $display("FAIL ovf_y got %h %h %h %h need %h %h %h %h",
                               y_re, y_im, y_re_w, y_im_w, e.re, e.im, e.re_w, e.im_w);
        end
        checks++;
        if ({ovf, ovf_w} !== {exp_ovf, exp_ovf_w}) begin
            errors++; $display("FAIL ovf_set got %b%b need %b%b", ovf, ovf_w, exp_ovf, exp_ovf_w);
        end
        tick;
        send(16'h0100, 16'h0000, 16'h0080, 16'h0080, 1'b0,
             mk(16'h0080, 16'h0080, 16'h0080, 16'h0080, 1'b0, 1'b0));
        wait_out(n);
        e = sb.pop_front(); exp_ovf |= e.ovf; exp_ovf_w |= e.ovf_w;
        checks++;
        if ({y_re, y_im, y_re_w, y_im_w} !== {e.re, e.im, e.re_w, e.im_w}) begin
            errors++; $display("FAIL ovf_clean_y got %h %h %h %h need %h %h %h %h",
                               y_re, y_im, y_re_w, y_im_w, e.re, e.im, e.re_w, e.im_w);
        end
        checks++;
        if ({ovf, ovf_w} !== {exp_ovf, exp_ovf_w}) begin
            errors++; $display("FAIL ovf_sticky got %b%b need %b%b", ovf, ovf_w, exp_ovf, exp_ovf_w);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [15:0] s_ar[8], s_ai[8], s_br[8], s_bi[8];
        logic        s_cj[8];
        logic [15:0] pat;
        logic [63:0] prev_y;
        logic        prev_stall, dup;
        exp_t        e;
        int          sent, got, cyc;
        s_ar[0] = 16'h0100; s_ai[0] = 16'h0000; s_br[0] = 16'h0080; s_bi[0] = 16'h0080;
        s_ar[1] = 16'h0100; s_ai[1] = 16'h0100; s_br[1] = 16'h0080; s_bi[1] = 16'h0080;
        s_ar[2] = 16'h8000; s_ai[2] = 16'h8000; s_br[2] = 16'h8000; s_bi[2] = 16'h8000;
        s_ar[3] = 16'h8000; s_ai[3] = 16'h8000; s_br[3] = 16'h8000; s_bi[3] = 16'h8000;
        for (int i = 0; i < 8; i++) begin
            s_cj[i] = i[0];
            if (i >= 4) begin
                s_ar[i] = 16'($urandom); s_ai[i] = 16'($urandom);
                s_br[i] = 16'($urandom); s_bi[i] = 16'($urandom);
            end
        end
        pat = 16'b0110_1001_1100_0101;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_y = '0;
        while (got < 8 && cyc < 300) begin
            out_ready = pat[cyc[3:0]];
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a_re = s_ar[sent]; a_im = s_ai[sent]; b_re = s_br[sent]; b_im = s_bi[sent];
                conj_en = s_cj[sent];
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (!out_valid || {y_re, y_im, y_re_w, y_im_w} !== prev_y) begin
                    errors++; $display("FAIL b2b_hold got %b %h need 1 %h", out_valid,
                                       {y_re, y_im, y_re_w, y_im_w}, prev_y);
                end
            end
            checks++;
            if (in_ready !== ~(out_valid & ~out_ready)) begin
                errors++; $display("FAIL b2b_ready got %b with out_valid=%b out_ready=%b",
                                   in_ready, out_valid, out_ready);
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(s_ar[sent], s_ai[sent], s_br[sent], s_bi[sent], s_cj[sent]));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_extra got output %h %h need none", y_re, y_im);
                end else begin
                    e = sb.pop_front(); exp_ovf |= e.ovf; exp_ovf_w |= e.ovf_w;
                    if ({y_re, y_im, y_re_w, y_im_w, ovf, ovf_w} !==
                        {e.re, e.im, e.re_w, e.im_w, exp_ovf, exp_ovf_w}) begin
                        errors++;
                        $display("FAIL b2b_y[%0d] got %h %h %h %h %b%b need %h %h %h %h %b%b",
                                 got, y_re, y_im, y_re_w, y_im_w, ovf, ovf_w,
                                 e.re, e.im, e.re_w, e.im_w, exp_ovf, exp_ovf_w);
                    end
                end
                got++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_y     = {y_re, y_im, y_re_w, y_im_w};
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != 8 || sb.size() != 0) begin
            errors++; $display("FAIL b2b_count got %0d outputs, %0d pending need 8, 0",
                               got, sb.size());
        end
        dup = 1'b0;
        repeat (6) begin
            if (out_valid) dup = 1'b1;
            tick;
        end
        checks++;
        if (dup) begin
            errors++; $display("FAIL b2b_duplicate got extra out_valid need none");
        end
    endtask

    task automatic test_reset_mid_flight;
        exp_t e; int n; logic seen;
        out_ready = 1'b0;
        send(16'h0100, 16'h0000, 16'h0080, 16'h0080, 1'b0,
             model(16'h0100, 16'h0000, 16'h0080, 16'h0080, 1'b0));
        send(16'h0200, 16'h0100, 16'h0040, 16'hff80, 1'b1,
             model(16'h0200, 16'h0100, 16'h0040, 16'hff80, 1'b1));
        send(16'h0300, 16'hfe00, 16'h0100, 16'h0010, 1'b0,
             model(16'h0300, 16'hfe00, 16'h0100, 16'h0010, 1'b0));
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_full got out_valid=%b need 1", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_valid_w, ovf, ovf_w, in_ready} !== 5'b00001 ||
            {y_re, y_im, y_re_w, y_im_w} !== 64'h0) begin
            errors++; $display("FAIL mid_reset got v=%b%b ovf=%b%b rdy=%b y=%h %h need 0 0 1 0",
                               out_valid, out_valid_w, ovf, ovf_w, in_ready, y_re, y_im);
        end
        sb.delete(); exp_ovf = 1'b0; exp_ovf_w = 1'b0;
        tick;
        tick;
        rst = 1'b0; out_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            if (out_valid || out_valid_w) seen = 1'b1;
            tick;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL mid_ghost got out_valid after reset need none");
        end
        send(16'h0100, 16'h0100, 16'h0080, 16'h0080, 1'b1,
             model(16'h0100, 16'h0100, 16'h0080, 16'h0080, 1'b1));
        wait_out(n);
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL mid_latency got %0d need 3", n);
        end
        e = sb.pop_front(); exp_ovf |= e.ovf; exp_ovf_w |= e.ovf_w;
        checks++;
        if ({y_re, y_im, y_re_w, y_im_w, ovf, ovf_w} !==
            {e.re, e.im, e.re_w, e.im_w, exp_ovf, exp_ovf_w}) begin
            errors++; $display("FAIL mid_first_y got %h %h %b need %h %h %b",
                               y_re, y_im, ovf, e.re, e.im, exp_ovf);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_conjugate;
        test_rounding;
        test_overflow;
        test_back_to_back;
        test_reset_mid_flight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/complex_mult_pipe.md
COMPLEX_MULT_PIPE -- requirements
Module: complex_mult_pipe

Interface
REQ-001 The block SHALL have the following parameters:
- WIDTH, 16, signed two's-complement width of each real/imag component.
- FRAC, WIDTH/2, number of fractional bits (Q(WIDTH-FRAC).FRAC format).
- ROUND, 1, selects rounding: 1 = round-half-up, 0 = truncate.
- SAT, 1, selects overflow handling: 1 = saturate, 0 = wrap.

REQ-002 The block SHALL have the following ports:
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- in_valid, in, 1, the input sample is valid.
- in_ready, out, 1, the block accepts input this cycle.
- a_re, a_im, in, WIDTH each, data operand (signed).
- b_re, b_im, in, WIDTH each, twiddle operand (signed).
- conj_en, in, 1, per-sample flag: use conj(b), for IFFT.
- out_valid, out, 1, the output sample is valid.
- out_ready, in, 1, the downstream consumer accepts the output.
- y_re, y_im, out, WIDTH each, product a*b (or a*conj(b)), signed.
- ovf, out, 1, sticky flag: at least one component overflowed since reset.

Function
REQ-003 The block SHALL compute y = a*b when conj_en=0 and y = a*conj(b) when conj_en=1, with conj_en sampled alongside its operands.
REQ-004 The block SHALL use a 3-stage pipeline:
- S1 registers the operands and conj_en.
- S2 registers the four full signed 2*WIDTH products ar*br, ai*bi, ar*bi, ai*br.
- S3 forms the sums, rounds, handles overflow, and registers y.
REQ-005 The re/im sums SHALL be computed at 2*WIDTH+1 bits signed with no intermediate truncation:
- re = ar*br - ai*bi, im = ar*bi + ai*br.
- When conj_en=1, the block uses re = ar*br + ai*bi and im = ai*br - ar*bi.
REQ-006 Scaling SHALL depend on ROUND:
- ROUND=1: the block adds 2^(FRAC-1) and then arithmetic-shifts right by FRAC.
- ROUND=0: the block arithmetic-shifts right by FRAC only (toward minus infinity).
REQ-007 Overflow SHALL depend on SAT:
- SAT=1: a scaled value above 2^(WIDTH-1)-1 becomes 2^(WIDTH-1)-1, and a value below -2^(WIDTH-1) becomes -2^(WIDTH-1).
- SAT=0: the block keeps the low WIDTH bits.
REQ-008 ovf SHALL be set in the cycle after S3 loads a sample whose scaled re or im lies outside the WIDTH signed range, regardless of SAT, and SHALL remain set until rst.
REQ-009 The handshake SHALL obey the following rules:
- A transfer occurs on any cycle with in_valid & in_ready, or out_valid & out_ready.
- stall = out_valid & ~out_ready, and in_ready = ~stall.
- While stall is high, every pipeline register, including the valid bits, SHALL hold its value.
REQ-010 Valid bits SHALL advance one stage per non-stalled cycle. Bubbles SHALL be preserved, not compressed. Latency from an accepted input to out_valid SHALL be exactly 3 cycles when out_ready is held at 1.
REQ-011 Throughput SHALL be one sample per cycle when out_ready=1, including back-to-back samples with alternating conj_en.
REQ-012 y_re and y_im SHALL hold stable while out_valid=1 and out_ready=0.
REQ-013 When out_ready rises in the same cycle that in_valid is high, the output SHALL transfer and the input SHALL be accepted in that cycle, with no lost or duplicated sample.
REQ-014 The -2^(WIDTH-1) operand cases, including (-1)*(-1) in full-scale terms, SHALL follow REQ-007 with no special-case sign logic.

Reset
REQ-015 When rst is asserted, the block SHALL asynchronously clear all valid bits, ovf, y_re, y_im and every data register to 0. in_ready SHALL then read 1.
REQ-016 Samples in flight when rst is asserted SHALL be discarded. After rst is released, the first out_valid SHALL come 3 cycles after the first accepted input.

Verification
REQ-017 The bench SHALL cover the following directed scenarios (defaults WIDTH=16, FRAC=8; values in hex):
- Basic: a=(0100,0000), b=(0080,0080), conj_en=0 -> y=(0080,0080) exactly 3 cycles after acceptance; ovf=0.
- Conjugate: a=(0100,0100), b=(0080,0080), conj_en=1 -> y=(0100,0000).
- Rounding: a=(0001,0000), b=(0080,0000) -> y_re=0001 with ROUND=1; y_re=0000 with ROUND=0.
- Overflow: a=(8000,0000), b=(FF00,0000) -> y_re=7FFF and ovf=1 with SAT=1; y_re=8000 and ovf=1 with SAT=0. ovf stays 1 on later clean samples.
- Backpressure: 8 back-to-back inputs with out_ready toggling in a pseudo-random pattern -> all 8 outputs arrive in order against the model, none lost or duplicated, and y holds stable while stalled.
- Reset mid-flight: assert rst with 3 samples in the pipeline -> out_valid drops immediately, outputs are 0, and none of the 3 samples appears after release.
